// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Request/response and data-memory bus between the execute
//               stage, the load/store unit and the word-addressed memory.
//               "slave" is the load/store unit's view; "master" is the
//               environment's view (execute stage plus memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_data, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_data, mem_read, mem_write
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Translates RV32I load/store requests into accesses of a
//               word-only data memory: lane select + sign/zero extension for
//               sub-word loads, read-modify-write for sub-word stores.
//               Optional macro MISALIGN_TRAP_EN: misaligned halfword/word
//               accesses complete with resp_err instead of touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_REQ  = 3'd1;
  localparam logic [2:0] S_LD_WAIT = 3'd2;
  localparam logic [2:0] S_ST_RD   = 3'd3;
  localparam logic [2:0] S_ST_MRG  = 3'd4;
  localparam logic [2:0] S_ST_WR   = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  logic [2:0]                  state_q, state_d;
  logic                        write_q;
  logic [2:0]                  f3_q;
  logic [MEM_DEPTH_LOG2+1:0]   addr_q;
  logic [31:0]                 wdata_q;
  logic [31:0]                 wbuf_q;
  logic [31:0]                 rdata_q;
  logic                        err_q;

  logic        accept;
  logic        req_illegal;
  logic        req_misalign;
  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] st_merge;
  logic        unused_addr_hi;

  // Address bits above the memory depth wrap and are deliberately dropped.
  assign unused_addr_hi = ^bus.req_addr[31:MEM_DEPTH_LOG2+2];

  assign bus.req_ready  = ~rst & (state_q == S_IDLE);
  assign accept         = bus.req_valid & bus.req_ready;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // Classify the request at the port: illegal encoding or trapped misalignment.
  always_comb begin
    // Store funct3 011 has no RV32I store behind it, so it is rejected too.
    if (bus.req_write)
      req_illegal = bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'b11);
    else
      req_illegal = (bus.req_funct3[1:0] == 2'b11) | (bus.req_funct3 == 3'b110);
`ifdef MISALIGN_TRAP_EN
    req_misalign = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                   ((bus.req_funct3[1:0] == 2'b10) & (bus.req_addr[1:0] != 2'b00));
`else
    req_misalign = 1'b0;
`endif
    req_err = req_illegal | req_misalign;
  end

  // Next-state sequencing of the load, store and error paths.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                           state_d = S_RESP;
          else if (!bus.req_write)               state_d = S_LD_REQ;
          else if (bus.req_funct3[1:0] == 2'b10) state_d = S_ST_WR;
          else                                   state_d = S_ST_RD;
        end
      end
      S_LD_REQ:  state_d = S_LD_WAIT;
      S_LD_WAIT: state_d = S_RESP;
      S_ST_RD:   state_d = S_ST_MRG;
      S_ST_MRG:  state_d = S_ST_WR;
      S_ST_WR:   state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane insertion for sub-word stores.
  always_comb begin
    ld_byte = bus.mem_data_out[8*addr_q[1:0] +: 8];
    ld_half = addr_q[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
    case (f3_q[1:0])
      2'b00:   ld_ext = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default: ld_ext = bus.mem_data_out;
    endcase
    st_merge = bus.mem_data_out;
    if (f3_q[1:0] == 2'b00)
      st_merge[8*addr_q[1:0] +: 8] = wdata_q[7:0];
    else if (addr_q[1])
      st_merge[31:16] = wdata_q[15:0];
    else
      st_merge[15:0] = wdata_q[15:0];
  end

  // Memory strobes follow the state; they fall as soon as rst rises.
  always_comb begin
    bus.mem_read  = ~rst & ((state_q == S_LD_REQ) | (state_q == S_ST_RD));
    bus.mem_write = ~rst & (state_q == S_ST_WR);
    bus.mem_addr  = 32'd0;
    bus.mem_data  = 32'd0;
    if ((state_q == S_LD_REQ) | (state_q == S_ST_RD) | (state_q == S_ST_WR))
      bus.mem_addr = {{(30-MEM_DEPTH_LOG2){1'b0}}, addr_q[MEM_DEPTH_LOG2+1:2]};
    if (state_q == S_ST_WR)
      bus.mem_data = (f3_q[1:0] == 2'b10) ? wdata_q : wbuf_q;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request latch, merge buffer and registered response fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      wbuf_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= bus.req_write;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr[MEM_DEPTH_LOG2+1:0];
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
        if (req_err) rdata_q <= 32'd0;
      end
      if (state_q == S_LD_WAIT) rdata_q <= ld_ext;
      if (state_q == S_ST_MRG)  wbuf_q  <= st_merge;
      if (state_q == S_ST_WR)   rdata_q <= 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a word memory
//               model and an arithmetic reference model of RV32I loads/stores.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  load_store_unit #(.MEM_DEPTH_LOG2(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = 10'd0;
  logic [31:0] pl_data = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory: read data appears the cycle after mem_read.
  always @(posedge clk) begin
    if (bus.mem_read === 1'b1)  bus.mem_data_out <= mem[bus.mem_addr[9:0]];
    if (bus.mem_write === 1'b1) mem[bus.mem_addr[9:0]] <= bus.mem_data;
    if (pl_en)                  mem[pl_addr] <= pl_data;
  end

  // Results of the last transaction.
  logic [31:0] t_rdata, t_wraddr, t_pre_rdata;
  logic        t_err, t_errc1, t_pre_valid, t_pre_err;
  int          t_lat, t_nrd, t_nwr;
  bit          t_rdy, t_to;

  function automatic bit model_err(bit w, logic [2:0] f3, logic [31:0] a);
    bit e;
    if (w) e = (f3 >= 3'd3);
    else   e = (f3 == 3'd3) || (f3 >= 3'd6);
`ifdef MISALIGN_TRAP_EN
    if (!e && (f3 % 4 == 1) && (a % 2 != 0)) e = 1'b1;
    if (!e && (f3 % 4 == 2) && (a % 4 != 0)) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] word, logic [2:0] f3, logic [31:0] a);
    int unsigned v;
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * (a % 4))) % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (word >> (16 * ((a / 2) % 2))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(logic [31:0] old, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    int unsigned sh;
    logic [31:0] mask;
    case (f3)
      3'd0: begin sh = 8 * (a % 4);        mask = 32'hFF << sh;   return (old & ~mask) | ((wd & 32'hFF) << sh); end
      3'd1: begin sh = 16 * ((a / 2) % 2); mask = 32'hFFFF << sh; return (old & ~mask) | ((wd & 32'hFFFF) << sh); end
      default: return wd;
    endcase
  endfunction

  function automatic int word_idx(logic [31:0] a);
    return int'((a / 4) % 1024);
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = idx[9:0]; pl_data = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Issue one request and follow it to its response (bounded wait).
  task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    t_pre_valid = bus.resp_valid; t_pre_rdata = bus.resp_rdata; t_pre_err = bus.resp_err;
    t_rdy = (bus.req_ready === 1'b1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom); bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    t_lat = 0; t_nrd = 0; t_nwr = 0; t_to = 1'b1; t_wraddr = 32'd0;
    t_rdata = 32'd0; t_err = 1'b0; t_errc1 = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) t_errc1 = bus.resp_err;
      if (bus.mem_read === 1'b1) t_nrd++;
      if (bus.mem_write === 1'b1) begin t_nwr++; t_wraddr = bus.mem_addr; end
      if (bus.resp_valid === 1'b1) begin
        t_lat = c; t_rdata = bus.resp_rdata; t_err = bus.resp_err; t_to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.resp_valid); end
    n_checks++; if (bus.resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata); end
    n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.resp_err); end
    n_checks++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {bus.mem_read, bus.mem_write}); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s  [6] = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd5, 3'd2};
    logic [31:0] adrs [6] = '{32'h16, 32'h16, 32'h14, 32'h16, 32'h14, 32'h14};
    logic [31:0] exps [6] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_0001,
                              32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    preload(5, 32'h80FF_7F01);
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, f3s[i], adrs[i], 32'd0);
      n_checks++; if (t_to) begin n_fail++; $display("FAIL load%0d_timeout: got none want resp", i); end
      n_checks++; if (t_rdata !== exps[i]) begin n_fail++; $display("FAIL load%0d_rdata: got %h want %h", i, t_rdata, exps[i]); end
      n_checks++; if (t_lat != 3 || t_err !== 1'b0) begin n_fail++; $display("FAIL load%0d_lat_err: got %0d/%b want 3/0", i, t_lat, t_err); end
      n_checks++; if (t_nrd != 1 || t_nwr != 0) begin n_fail++; $display("FAIL load%0d_strobes: got rd%0d wr%0d want rd1 wr0", i, t_nrd, t_nwr); end
    end
  endtask

  task automatic test_stores;
    preload(2, 32'h1122_3344);
    do_req(1'b1, 3'd0, 32'h09, 32'hAAAA_AA55);
    n_checks++; if (mem[2] !== 32'h1122_5544) begin n_fail++; $display("FAIL sb_word: got %h want 11225544", mem[2]); end
    n_checks++; if (t_lat != 4 || t_nwr != 1 || t_nrd != 1) begin n_fail++; $display("FAIL sb_timing: got lat%0d wr%0d rd%0d want 4/1/1", t_lat, t_nwr, t_nrd); end
    do_req(1'b1, 3'd1, 32'h0A, 32'h0000_BEEF);
    n_checks++; if (mem[2] !== 32'hBEEF_5544) begin n_fail++; $display("FAIL sh_word: got %h want beef5544", mem[2]); end
    n_checks++; if (t_lat != 4 || t_nwr != 1 || t_nrd != 1) begin n_fail++; $display("FAIL sh_timing: got lat%0d wr%0d rd%0d want 4/1/1", t_lat, t_nwr, t_nrd); end
    n_checks++; if (t_rdata !== 32'd0 || t_err !== 1'b0) begin n_fail++; $display("FAIL sh_resp: got %h/%b want 0/0", t_rdata, t_err); end
    do_req(1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF);
    n_checks++; if (t_nwr != 1 || t_wraddr !== 32'd16 || t_nrd != 0) begin n_fail++; $display("FAIL sw_bus: got wr%0d addr%0d rd%0d want 1/16/0", t_nwr, t_wraddr, t_nrd); end
    n_checks++; if (t_lat != 2) begin n_fail++; $display("FAIL sw_lat: got %0d want 2", t_lat); end
    n_checks++; if (mem[16] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_word: got %h want deadbeef", mem[16]); end
    ref_mem[2] = 32'hBEEF_5544; ref_mem[16] = 32'hDEAD_BEEF;
  endtask

  task automatic test_errors;
    logic [31:0] exp_rd;
    bit          exp_e;
    do_req(1'b0, 3'd3, 32'h0, 32'd0);
    n_checks++; if (t_err !== 1'b1 || t_rdata !== 32'd0) begin n_fail++; $display("FAIL err011_resp: got %b/%h want 1/0", t_err, t_rdata); end
    n_checks++; if (t_lat != 1 || t_nrd != 0 || t_nwr != 0) begin n_fail++; $display("FAIL err011_bus: got lat%0d rd%0d wr%0d want 1/0/0", t_lat, t_nrd, t_nwr); end
    do_req(1'b1, 3'd4, 32'h20, 32'h1234_5678);
    n_checks++; if (t_err !== 1'b1 || t_nwr != 0 || t_lat != 1) begin n_fail++; $display("FAIL err_st100: got %b wr%0d lat%0d want 1/0/1", t_err, t_nwr, t_lat); end
    preload(4, 32'hCAFE_0004);
`ifdef MISALIGN_TRAP_EN
    exp_e = 1'b1; exp_rd = 32'd0;
`else
    exp_e = 1'b0; exp_rd = 32'hCAFE_0004;
`endif
    do_req(1'b0, 3'd2, 32'h13, 32'd0);
    n_checks++; if (t_err !== exp_e || t_rdata !== exp_rd) begin n_fail++; $display("FAIL lw_misalign: got %b/%h want %b/%h", t_err, t_rdata, exp_e, exp_rd); end
    do_req(1'b0, 3'd0, 32'h14, 32'd0);
    n_checks++; if (t_pre_valid !== 1'b0 || t_pre_err !== exp_e || t_pre_rdata !== exp_rd) begin n_fail++; $display("FAIL resp_hold: got %b/%b/%h want 0/%b/%h", t_pre_valid, t_pre_err, t_pre_rdata, exp_e, exp_rd); end
    n_checks++; if (t_errc1 !== 1'b0 || t_rdata !== 32'h1) begin n_fail++; $display("FAIL err_clear: got %b/%h want 0/1", t_errc1, t_rdata); end
  endtask

  task automatic test_back_to_back;
    bit          w, e, first;
    logic [2:0]  f3;
    logic [31:0] a, wd, prev_rd, exp_rd, exp_w;
    bit          prev_e;
    int          exp_lat, idx;
    first = 1'b1;
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom);
      f3 = 3'($urandom);
      if (w && f3 == 3'd3) f3 = 3'd2;
      a  = $urandom; wd = $urandom;
      idx = word_idx(a);
      e = model_err(w, f3, a);
      exp_lat = e ? 1 : (!w ? 3 : (f3 == 3'd2 ? 2 : 4));
      exp_rd  = (e || w) ? 32'd0 : model_load(ref_mem[idx], f3, a);
      exp_w   = model_store(ref_mem[idx], f3, a, wd);
      do_req(w, f3, a, wd);
      n_checks++;
      if (t_to || !t_rdy || t_lat != exp_lat || t_err !== e || t_rdata !== exp_rd || t_errc1 !== e) begin
        n_fail++;
        $display("FAIL rand%0d w%0d f3=%0d a=%h: got lat%0d err%b rd%h rdy%0d want lat%0d err%b rd%h rdy1",
                 i, w, f3, a, t_lat, t_err, t_rdata, t_rdy, exp_lat, e, exp_rd);
      end
      if (!first) begin
        n_checks++;
        if (t_pre_valid !== 1'b0 || t_pre_rdata !== prev_rd || t_pre_err !== prev_e) begin
          n_fail++; $display("FAIL rand%0d_hold: got %b/%h/%b want 0/%h/%b", i, t_pre_valid, t_pre_rdata, t_pre_err, prev_rd, prev_e);
        end
      end
      if (w && !e) begin
        ref_mem[idx] = exp_w;
        n_checks++;
        if (mem[idx] !== exp_w || t_nwr != 1 || t_wraddr !== 32'(idx)) begin
          n_fail++; $display("FAIL rand%0d_store: got %h wr%0d @%0d want %h wr1 @%0d", i, mem[idx], t_nwr, t_wraddr, exp_w, idx);
        end
      end else begin
        n_checks++;
        if (t_nwr != 0 || t_nrd != ((e) ? 0 : 1)) begin
          n_fail++; $display("FAIL rand%0d_strobes: got rd%0d wr%0d want rd%0d wr0", i, t_nrd, t_nwr, e ? 0 : 1);
        end
      end
      prev_rd = exp_rd; prev_e = e; first = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    bit saw_resp, saw_wr;
    preload(2, 32'h1122_3344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h09; bus.req_wdata = 32'hAAAA_AA55;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if ({bus.mem_read, bus.mem_write, bus.req_ready} !== 3'b000) begin n_fail++; $display("FAIL rstmid_outputs: got %b want 000", {bus.mem_read, bus.mem_write, bus.req_ready}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", bus.req_ready); end
    saw_resp = 1'b0; saw_wr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.resp_valid === 1'b1) saw_resp = 1'b1;
      if (bus.mem_write === 1'b1)  saw_wr = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (saw_resp || saw_wr) begin n_fail++; $display("FAIL rstmid_quiet: got resp%0d wr%0d want 0/0", saw_resp, saw_wr); end
    n_checks++; if (mem[2] !== 32'h1122_3344) begin n_fail++; $display("FAIL rstmid_word: got %h want 11223344", mem[2]); end
    do_req(1'b0, 3'd2, 32'h08, 32'd0);
    n_checks++; if (t_rdata !== 32'h1122_3344 || t_lat != 3) begin n_fail++; $display("FAIL rstmid_after: got %h lat%0d want 11223344 lat3", t_rdata, t_lat); end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 1024; i++) preload(i, $urandom);
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of test want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits directly upstream of the word-addressed data memory in the rv32i core and translates RV32I load/store requests into memory accesses.
- Byte and halfword loads: byte lane selection, then sign or zero extension.
- Sub-word stores: read-modify-write, because the memory only writes whole words.
- Request handshake to the execute stage; single-cycle response pulse back to writeback.

Parameters:
MEM_DEPTH_LOG2, 10, log2 of memory depth in 32-bit words; word index = req_addr[MEM_DEPTH_LOG2+1:2], upper address bits ignored (wrap).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  unit idle, request accepted on clk edge when req_valid & req_ready
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
req_addr  input  32  byte address
req_wdata  input  32  store data (low byte/half used for SB/SH)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  illegal funct3 (or misaligned, see feature); valid with resp_valid
mem_addr  output  32  word index to memory, zero-extended
mem_data  output  32  write data to memory
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_data_out  input  32  memory read data, valid the cycle after mem_read

Behaviour:
- On accept, latch req_write, req_funct3, req_addr, req_wdata.
- mem_* signals are decoded combinationally from the state plus the latched request. They are 0 in all other states.
- FSM states:
  - IDLE
  - LD_REQ: mem_read=1
  - LD_WAIT: capture extended data
  - ST_RD: mem_read=1
  - ST_MRG: merge lane into captured word, register into wbuf
  - ST_WR: mem_write=1, mem_data=wbuf (SW: latched wdata)
  - RESP: resp_valid=1
- Transitions:
  - IDLE -> LD_REQ for legal loads.
  - IDLE -> ST_WR for SW.
  - IDLE -> ST_RD for SB/SH.
  - IDLE -> RESP with resp_err=1 for an illegal funct3. Illegal encodings: 011, 110, 111 for loads; bit2 set for stores. No memory strobe is issued.
  - LD_REQ -> LD_WAIT -> RESP.
  - ST_RD -> ST_MRG -> ST_WR -> RESP.
  - RESP -> IDLE.
- req_ready = (state==IDLE); it is 0 while rst is high.
- Back-to-back requests: the next accept is possible in the cycle after RESP.
- Latency, from the accept edge to the resp_valid cycle:
  - LW/LH/LB: 3 cycles.
  - SW: 2 cycles.
  - SB/SH: 4 cycles.
  - Error: 1 cycle.
- Lane select uses addr[1:0]:
  - Byte: bits [8*a+7:8*a].
  - Half: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- SB/SH merge: replace only the selected lane. All other bits come from the word read in ST_RD.
- resp_rdata and resp_err are registered. They hold their value outside RESP, except that resp_err clears on the next accept.
- Reset values: state IDLE; resp_valid 0, resp_rdata 0, resp_err 0, wbuf 0. mem_read and mem_write drop to 0 immediately on rst assertion.
- Reset mid-operation: the in-flight request is abandoned and no response is produced.
  - A store interrupted before ST_WR leaves memory unchanged.
  - Asserting rst during ST_WR may or may not commit the write (clk/rst race). This is documented, not checked.
- Request inputs are ignored while req_ready is 0.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, complete via IDLE -> RESP with resp_err=1 and no memory access.
- Undefined: misaligned low bits are silently ignored. Halfword uses addr[1] only; word uses the word index only. Such accesses are never flagged.

Test Plan:
- Preload word 5 = 0x80FF_7F01; LB addr 0x16 -> resp_rdata 0xFFFF_FFFF three cycles after accept; LBU 0x16 -> 0x0000_00FF; LB 0x14 -> 0x0000_0001.
- Same word; LH 0x16 -> 0xFFFF_80FF; LHU 0x14 -> 0x0000_7F01; LW 0x14 -> 0x80FF_7F01.
- Word 2 = 0x1122_3344; SB addr 0x09 wdata 0xAAAA_AA55 -> word 2 = 0x1122_5544. SH addr 0x0A wdata 0x0000_BEEF -> word 2 = 0xBEEF_5544. Each completes in 4 cycles with mem_write high exactly one cycle.
- SW addr 0x40 wdata 0xDEAD_BEEF -> one mem_write with mem_addr 16; mem_read never asserted; resp_valid 2 cycles after accept.
- Illegal load funct3 011 at 0x0 -> resp_err=1, resp_rdata 0, no mem strobe. With MISALIGN_TRAP_EN: LW 0x13 -> resp_err=1. Without it: LW 0x13 returns word 4.
- Assert rst during ST_MRG of SB at 0x09 -> req_ready high next cycle after release, no resp_valid, word 2 unchanged.
